// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM states, stall patterns,
// and the stage-priority merge of stall requests.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN      = 2'd0,
    PC_EXC_WAIT = 2'd1,
    PC_FLUSH    = 2'd2
  } pc_state_e;

  // Bit order: [0]=pc [1]=if [2]=id [3]=exe [4]=mem [5]=wb; WB is never held.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EXE  = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  function automatic logic [5:0] stall_prio(input logic id, input logic exe, input logic mem);
    if (mem)      return STALL_MEM;
    else if (exe) return STALL_EXE;
    else if (id)  return STALL_ID;
    else          return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the sequencer: stall requests and
// exceptions in, stall vector, flush redirect and statistics out.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  logic             stallreq_id;
  logic             stallreq_exe;
  logic             stallreq_mem;
  logic             exc_valid;
  logic [31:0]      exc_target;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             hang;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output stallreq_id, stallreq_exe, stallreq_mem, exc_valid, exc_target,
    input  stall, flush, new_pc, hang, stall_cycles, flush_count
  );

  modport slave (
    input  stallreq_id, stallreq_exe, stallreq_mem, exc_valid, exc_target,
    output stall, flush, new_pc, hang, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that holds at MAX instead of wrapping; clr has priority over inc.
module sat_counter #(
  parameter int           W   = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     q_q <= '0;
    else if (clr_i)                q_q <= '0;
    else if (inc_i && q_q != MAX)  q_q <= q_q + 1'b1;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, sequences exception flushes
// (deferred behind in-flight data-RAM accesses), and keeps stall statistics/watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  bus
);

  localparam int              WD_W   = $clog2(WDOG_LIMIT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT - 1);

  pc_state_e        state_q, state_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [31:0]      new_pc_q;
  logic             flush_q;
  logic             hang_q;
  logic [5:0]       stall;
  logic             stalled;
  logic [WD_W-1:0]  wdog;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    stall   = stall_prio(bus.stallreq_id, bus.stallreq_exe, bus.stallreq_mem);
    case (state_q)
      PC_RUN: begin
        if (bus.exc_valid) begin
          tgt_d   = bus.exc_target;
          state_d = bus.stallreq_mem ? PC_EXC_WAIT : PC_FLUSH;
        end
      end
      // Later exceptions come from younger instructions; the first one is kept.
      PC_EXC_WAIT: begin
        if (!bus.stallreq_mem) state_d = PC_FLUSH;
      end
      // Everything in flight is being squashed, so its requests are meaningless.
      PC_FLUSH: begin
        stall   = STALL_NONE;
        state_d = PC_RUN;
      end
      default: state_d = PC_RUN;
    endcase
  end

  assign stalled = (stall != STALL_NONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PC_RUN;
      tgt_q    <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      hang_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      flush_q  <= (state_d == PC_FLUSH);
      new_pc_q <= (state_d == PC_FLUSH) ? tgt_d : '0;
      if (stalled && wdog == WD_MAX) hang_q <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (stalled),
    .clr_i (1'b0),
    .q_o   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (state_q == PC_FLUSH),
    .clr_i (1'b0),
    .q_o   (flush_count)
  );

  // Any unstalled cycle (including FLUSH) restarts the consecutive-stall run.
  sat_counter #(.W(WD_W), .MAX(WD_MAX)) u_wdog (
    .clk   (clk),
    .reset (reset),
    .inc_i (stalled),
    .clr_i (!stalled),
    .q_o   (wdog)
  );

  assign bus.stall        = stall;
  assign bus.flush        = flush_q;
  assign bus.new_pc       = new_pc_q;
  assign bus.hang         = hang_q;
  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_count  = flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception flush sequencing,
// deferred flush behind mem stalls, watchdog and reset behaviour.
module tb_pipe_ctrl;

  logic clk;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(.WDOG_LIMIT(8), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic exe, input logic mem,
                       input logic ev, input logic [31:0] tgt);
    bus.stallreq_id  = id;
    bus.stallreq_exe = exe;
    bus.stallreq_mem = mem;
    bus.exc_valid    = ev;
    bus.exc_target   = tgt;
    #2;
  endtask

  initial begin
    reset = 1'b1;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_exe = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.exc_valid    = 1'b0;
    bus.exc_target   = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall",  {26'd0, bus.stall}, 32'h0);
    chk("rst_flush",  {31'd0, bus.flush}, 32'h0);
    chk("rst_newpc",  bus.new_pc, 32'h0);
    chk("rst_hang",   {31'd0, bus.hang}, 32'h0);
    chk("rst_scnt",   bus.stall_cycles, 32'd0);
    chk("rst_fcnt",   bus.flush_count, 32'd0);
    reset = 1'b0;

    // 1: id stall, combinational
    next_cyc(); drive(1, 0, 0, 0, 32'h0);
    chk("t1_stall_id", {26'd0, bus.stall}, 32'h07);
    chk("t1_scnt0",    bus.stall_cycles, 32'd0);
    // 2: priority
    next_cyc(); drive(1, 1, 1, 0, 32'h0);
    chk("t1_scnt1",    bus.stall_cycles, 32'd1);
    chk("t2_stall_mem", {26'd0, bus.stall}, 32'h1F);
    next_cyc(); drive(1, 1, 0, 0, 32'h0);
    chk("t2_stall_exe", {26'd0, bus.stall}, 32'h0F);
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("t2_stall_none", {26'd0, bus.stall}, 32'h0);
    chk("t2_scnt3",    bus.stall_cycles, 32'd3);

    // 3: exception, no stalls
    next_cyc(); drive(0, 0, 0, 1, 32'hBFC00380);
    chk("t3_noflush_n", {31'd0, bus.flush}, 32'h0);
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("t3_flush",    {31'd0, bus.flush}, 32'h1);
    chk("t3_newpc",    bus.new_pc, 32'hBFC00380);
    chk("t3_stall0",   {26'd0, bus.stall}, 32'h0);
    chk("t3_fcnt0",    bus.flush_count, 32'd0);
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("t3_flush_off", {31'd0, bus.flush}, 32'h0);
    chk("t3_fcnt1",    bus.flush_count, 32'd1);

    // exception coincident with id stall: id drives stall now, dropped in FLUSH
    next_cyc(); drive(1, 0, 0, 1, 32'h00001234);
    chk("co_stall_id", {26'd0, bus.stall}, 32'h07);
    next_cyc(); drive(1, 0, 0, 0, 32'h0);
    chk("co_flush",    {31'd0, bus.flush}, 32'h1);
    chk("co_newpc",    bus.new_pc, 32'h00001234);
    chk("co_stall_drop", {26'd0, bus.stall}, 32'h0);
    chk("co_scnt4",    bus.stall_cycles, 32'd4);
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("co_fcnt2",    bus.flush_count, 32'd2);
    chk("co_scnt4b",   bus.stall_cycles, 32'd4);

    // 4: exception deferred behind mem stall; second exception ignored
    next_cyc(); drive(0, 0, 1, 1, 32'h80000180);
    chk("t4_stall_c1", {26'd0, bus.stall}, 32'h1F);
    next_cyc(); drive(0, 0, 1, 1, 32'h00000000);
    chk("t4_stall_c2", {26'd0, bus.stall}, 32'h1F);
    chk("t4_noflush2", {31'd0, bus.flush}, 32'h0);
    next_cyc(); drive(0, 0, 1, 0, 32'h0);
    chk("t4_stall_c3", {26'd0, bus.stall}, 32'h1F);
    chk("t4_noflush3", {31'd0, bus.flush}, 32'h0);
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("t4_noflush4", {31'd0, bus.flush}, 32'h0);
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("t4_flush",    {31'd0, bus.flush}, 32'h1);
    chk("t4_newpc",    bus.new_pc, 32'h80000180);
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("t4_flush_off", {31'd0, bus.flush}, 32'h0);
    chk("t4_fcnt3",    bus.flush_count, 32'd3);
    chk("t4_scnt7",    bus.stall_cycles, 32'd7);

    // 5: watchdog with limit 8, exe stall for 10 cycles
    for (int i = 1; i <= 10; i++) begin
      next_cyc(); drive(0, 1, 0, 0, 32'h0);
      if (i == 8) chk("t5_hang_c8", {31'd0, bus.hang}, 32'h0);
      if (i == 9) chk("t5_hang_c9", {31'd0, bus.hang}, 32'h1);
    end
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("t5_hang_sticky", {31'd0, bus.hang}, 32'h1);
    chk("t5_scnt17",   bus.stall_cycles, 32'd17);
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("t5_hang_sticky2", {31'd0, bus.hang}, 32'h1);
    reset = 1'b1;
    #2;
    chk("t5_rst_hang", {31'd0, bus.hang}, 32'h0);
    chk("t5_rst_scnt", bus.stall_cycles, 32'd0);
    chk("t5_rst_fcnt", bus.flush_count, 32'd0);
    next_cyc();
    reset = 1'b0;

    // 6: reset during EXC_WAIT discards the pending flush
    next_cyc(); drive(0, 0, 1, 1, 32'hDEADBEEF);
    next_cyc(); drive(0, 0, 1, 0, 32'h0);
    chk("t6_wait_stall", {26'd0, bus.stall}, 32'h1F);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 32'h0);
    chk("t6_stall_none", {26'd0, bus.stall}, 32'h0);
    next_cyc(); drive(1, 0, 0, 0, 32'h0);
    chk("t6_noflush1", {31'd0, bus.flush}, 32'h0);
    chk("t6_newpc0",   bus.new_pc, 32'h0);
    chk("t6_stall_id", {26'd0, bus.stall}, 32'h07);
    next_cyc(); drive(0, 0, 0, 0, 32'h0);
    chk("t6_noflush2", {31'd0, bus.flush}, 32'h0);
    chk("t6_fcnt0",    bus.flush_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
